// File: rtl/tttg_auto_player.sv
// tttg_auto_player: automated player-2 driver for the 2x2 tic-tac-toe game.
// Define TTT_RANDOM_MOVE_EN for LFSR-seeded move choice; default is lowest empty cell.
module tttg_auto_player #(
  parameter int THINK_CYCLES   = 16,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] who,
  output logic       play2,
  output logic [3:0] button,
  output logic       busy,
  output logic       err
);

  localparam int M1 = (THINK_CYCLES > HOLD_CYCLES) ? THINK_CYCLES : HOLD_CYCLES;
  localparam int M2 = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam int CW = $clog2(M2) + 1;

  localparam logic [CW-1:0] THINK_LAST = CW'(THINK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_THINK,
    S_ARM,
    S_PRESS,
    S_RELEASE,
    S_CONFIRM,
    S_OVER
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [1:0]      r_cell;
  logic [1:0]      w_cell_nxt;
  logic            r_err;
  logic            w_err_set;

  logic [1:0]      w_pos [4];
  logic [3:0]      w_empty;
  logic [2:0]      w_n1;
  logic [2:0]      w_n2;
  logic [1:0]      w_pick;
  logic            w_turn;
  logic            w_hit;

  assign w_pos[0] = pos1;
  assign w_pos[1] = pos2;
  assign w_pos[2] = pos3;
  assign w_pos[3] = pos4;

`ifdef TTT_RANDOM_MOVE_EN
  logic [7:0] r_lfsr;

  // Free-running x^8+x^6+x^5+x^4+1 sequence seeding the search start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0],
                 r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end
`endif

  // Board census and candidate cell for the next move
  always_comb begin
    w_n1    = '0;
    w_n2    = '0;
    w_empty = '0;
    w_pick  = '0;
    for (int i = 0; i < 4; i++) begin
      w_empty[i] = (w_pos[i] == 2'b00);
      if (w_pos[i] == 2'b01) w_n1 = w_n1 + 3'd1;
      if (w_pos[i] == 2'b10) w_n2 = w_n2 + 3'd1;
    end
    for (int j = 3; j >= 0; j--) begin
`ifdef TTT_RANDOM_MOVE_EN
      if (w_empty[r_lfsr[1:0] + 2'(j)]) w_pick = r_lfsr[1:0] + 2'(j);
`else
      if (w_empty[j]) w_pick = 2'(j);
`endif
    end
  end

  assign w_turn = enable && (who == 2'b00) &&
                  (w_n1 == w_n2 + 3'd1) && (|w_empty);
  assign w_hit  = (w_pos[r_cell] == 2'b10);
  assign err    = r_err;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase counter, latched cell and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_cell <= '0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_cell <= w_cell_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Next-state and strobe outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_cell_nxt  = r_cell;
    w_err_set   = 1'b0;
    play2       = 1'b0;
    button      = 4'b0000;
    busy        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (who != 2'b00) begin
          w_state_nxt = S_OVER;
        end else if (w_turn) begin
          w_state_nxt = S_THINK;
        end
      end
      S_THINK: begin
        busy = 1'b1;
        if (!w_turn) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == THINK_LAST) begin
          w_state_nxt = S_ARM;
          w_cnt_nxt   = '0;
          w_cell_nxt  = w_pick;
        end
      end
      S_ARM: begin
        busy  = 1'b1;
        play2 = 1'b1;
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS: begin
        busy   = 1'b1;
        play2  = 1'b1;
        button = 4'b0001 << r_cell;
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE: begin
        busy = 1'b1;
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_CONFIRM;
          w_cnt_nxt   = '0;
        end
      end
      S_CONFIRM: begin
        busy = 1'b1;
        if (w_hit) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_err_set   = 1'b1;
        end
      end
      S_OVER: begin
        w_cnt_nxt = '0;
        if (w_empty == 4'b1111) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tttg_auto_player.sv
// tb_tttg_auto_player: time-based reference model plus directed and random play.
// Game responder writes player-2 marks after each pressed strobe.
module tb_tttg_auto_player;

  localparam int TH = 16;
  localparam int HO = 8;
  localparam int TO = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] pos [4];
  logic [1:0] who;
  logic       play2;
  logic [3:0] button;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  bit game_on = 1'b0;
  bit pend    = 1'b0;
  int pend_cell = 0;

  tttg_auto_player #(
    .THINK_CYCLES(TH),
    .HOLD_CYCLES(HO),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pos1(pos[0]),
    .pos2(pos[1]),
    .pos3(pos[2]),
    .pos4(pos[3]),
    .who(who),
    .play2(play2),
    .button(button),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: a move is a timeline measured from its start edge
  int       m_cyc = 0;
  int       m_t0  = 0;
  int       m_cell = 0;
  bit       m_mv  = 1'b0;
  bit       m_ov  = 1'b0;
  bit       m_err = 1'b0;
  bit [7:0] m_lfsr = 8'hA5;

  function automatic bit m_turn();
    int n1 = 0;
    int n2 = 0;
    int ne = 0;
    for (int i = 0; i < 4; i++) begin
      if (pos[i] == 2'b01) n1++;
      if (pos[i] == 2'b10) n2++;
      if (pos[i] == 2'b00) ne++;
    end
    return enable && (who == 2'b00) && (n1 == n2 + 1) && (ne > 0);
  endfunction

  function automatic int m_pick();
    int s = 0;
`ifdef TTT_RANDOM_MOVE_EN
    s = int'(m_lfsr[1:0]);
`endif
    for (int j = 0; j < 4; j++)
      if (pos[(s + j) % 4] == 2'b00) return (s + j) % 4;
    return 0;
  endfunction

  function automatic logic [6:0] m_expect();
    int         e;
    logic       p;
    logic [3:0] b;
    if (!m_mv) return {6'b0, 1'(m_err)};
    e = m_cyc - m_t0;
    p = (e >= TH) && (e < TH + 2 * HO);
    b = ((e >= TH + HO) && (e < TH + 2 * HO)) ? 4'(1 << m_cell) : 4'b0;
    return {p, b, 1'b1, 1'(m_err)};
  endfunction

  always @(posedge clk) begin
    int e;
    m_cyc++;
    if (reset) begin
      m_mv   = 1'b0;
      m_ov   = 1'b0;
      m_err  = 1'b0;
      m_lfsr = 8'hA5;
    end else begin
      e = m_cyc - m_t0;
      if (m_mv) begin
        if (e <= TH) begin
          if (!m_turn()) m_mv = 1'b0;
          else if (e == TH) m_cell = m_pick();
        end else if (e > TH + 3 * HO) begin
          if (pos[m_cell] == 2'b10) begin
            m_mv = 1'b0;
          end else if (e == TH + 3 * HO + TO) begin
            m_err = 1'b1;
            m_mv  = 1'b0;
          end
        end
      end else if (m_ov) begin
        if (pos[0] == 2'b00 && pos[1] == 2'b00 &&
            pos[2] == 2'b00 && pos[3] == 2'b00) m_ov = 1'b0;
      end else if (who != 2'b00) begin
        m_ov = 1'b1;
      end else if (m_turn()) begin
        m_mv = 1'b1;
        m_t0 = m_cyc;
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // One cycle: compare against model, then let the game react
  task automatic step();
    logic [6:0] got;
    logic [6:0] exp;
    @(negedge clk);
    got = {play2, button, busy, err};
    exp = m_expect();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL outputs cyc %0d: got %b want %b (play2,button,busy,err)",
               m_cyc, got, exp);
    end
    if (play2 && button != 4'b0) begin
      pend = 1'b1;
      for (int i = 0; i < 4; i++) if (button[i]) pend_cell = i;
    end else if (pend && !play2 && game_on) begin
      pos[pend_cell] = 2'b10;
      pend = 1'b0;
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 4; i++) pos[i] = 2'b00;
  endtask

  task automatic rand_board();
    int k;
    int n2;
    int idx;
    k = $urandom_range(0, 3);
    clear_board();
    if (k == 1) begin
      for (int i = 0; i < 4; i++) pos[i] = 2'($urandom_range(0, 3));
    end else if (k >= 2) begin
      n2 = $urandom_range(0, 1);
      for (int m = 0; m < 2 * n2 + 1; m++) begin
        idx = $urandom_range(0, 3);
        for (int t = 0; t < 4 && pos[idx] != 2'b00; t++) idx = (idx + 1) % 4;
        pos[idx] = (m <= n2) ? 2'b01 : 2'b10;
      end
    end
  endtask

  task automatic wait_sig(input int which, input bit lvl, input int lim, output int k);
    k = 0;
    while (k < lim) begin
      if (which == 0 && play2 == lvl) break;
      if (which == 1 && (button != 4'b0) == lvl) break;
      if (which == 2 && busy == lvl) break;
      if (which == 3 && err == lvl) break;
      step();
      k++;
    end
  endtask

  initial begin
    int k;
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    who    = 2'b00;
    clear_board();

    repeat (10) step();
    check("reset_outputs", int'({play2, button, busy, err}), 0);
    reset  = 1'b0;
    enable = 1'b1;
    repeat (5) step();
    check("idle_empty_board", int'({play2, button, busy, err}), 0);

    game_on = 1'b1;
    pos[0] = 2'b01;
    k = 0;
    do begin step(); k++; end while (!play2 && k < 100);
    check("think_latency", k, TH + 1);
    wait_sig(1, 1'b1, 50, k);
    check("arm_len", k, HO);
    check("press_button", int'(button), 2);
    n = 0;
    while (button != 4'b0 && n < 50) begin n++; step(); end
    check("press_len", n, HO);
    check("play2_falls_with_button", int'(play2), 0);
    wait_sig(2, 1'b0, 100, k);
    check("confirm_done_busy", int'(busy), 0);
    check("no_err_after_move", int'(err), 0);

    pos[2] = 2'b01;
    wait_sig(1, 1'b1, 100, k);
    check("choose_pos4", int'(button), 8);
    wait_sig(2, 1'b0, 100, k);

    game_on = 1'b0;
    pend = 1'b0;
    clear_board();
    repeat (2) step();
    pos[0] = 2'b01;
    wait_sig(0, 1'b1, 100, k);
    wait_sig(0, 1'b0, 50, k);
    wait_sig(3, 1'b1, 400, k);
    check("timeout_latency", k, HO + TO);
    check("timeout_idle_busy", int'(busy), 0);
    pend = 1'b0;
    game_on = 1'b1;
    wait_sig(0, 1'b1, 100, k);
    wait_sig(2, 1'b0, 100, k);
    check("move_after_err_done", int'(pos[1]), 2);
    check("err_sticky", int'(err), 1);

    pos[2] = 2'b01;
    repeat (5) step();
    who = 2'b01;
    n = 0;
    for (int c = 0; c < 60; c++) begin step(); if (play2) n++; end
    check("abort_no_play2", n, 0);
    check("over_busy", int'(busy), 0);
    clear_board();
    who = 2'b00;
    repeat (3) step();
    pos[0] = 2'b01;
    k = 0;
    do begin step(); k++; end while (!play2 && k < 100);
    check("over_exit_latency", k, TH + 1);
    wait_sig(2, 1'b0, 100, k);

    clear_board();
    repeat (2) step();
    pos[0] = 2'b01;
    wait_sig(1, 1'b1, 60, k);
    check("s6_button", int'(button), 2);
    n = 0;
    while (button != 4'b0 && n < 50) begin
      n++;
      if (n == 3) enable = 1'b0;
      step();
    end
    check("press_len_enable_low", n, HO);
    wait_sig(2, 1'b0, 60, k);
    check("s6_confirm_busy", int'(busy), 0);
    pos[2] = 2'b01;
    n = 0;
    for (int c = 0; c < 60; c++) begin step(); if (play2 || busy) n++; end
    check("disabled_no_move", n, 0);
    enable = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 63) == 0) rand_board();
      if ($urandom_range(0, 99) == 0) enable = ($urandom_range(0, 3) != 0);
      if (who == 2'b00) begin
        if ($urandom_range(0, 149) == 0) who = 2'($urandom_range(1, 3));
      end else if ($urandom_range(0, 39) == 0) begin
        who = 2'b00;
      end
      if ($urandom_range(0, 99) == 0) game_on = ($urandom_range(0, 4) != 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
